mem_stage_wb_reg: RTL
=====================

Name: mem_stage_wb_reg

Overview:
MEM stage of the 5-stage pipeline. It consumes the EX/MEM register outputs and performs the data-memory access through a req/ack handshake, holding the upstream pipeline with a stall while the memory is busy. It also implements the MEM/WB pipeline register that feeds the write-back mux and the register file. A timeout watchdog converts a hung access into a bubble and raises a sticky error flag.

Parameters:
DATA_W, 21, datapath width (ALU result, store data, load data)
ADDR_W, 16, data-memory address width; address = alu_in[ADDR_W-1:0]
REG_W, 4, register-index width
MAX_WAIT, 255, maximum cycles spent in WAIT before timeout (>=2)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-high
MemToReg_in  in  1  EX/MEM: write-back selects load data
MemRead_in  in  1  EX/MEM: load
MemWrite_in  in  1  EX/MEM: store
RegWrite_in  in  1  EX/MEM: register-file write enable
alu_in  in  DATA_W  EX/MEM: ALU result / effective address
RD3_in  in  DATA_W  EX/MEM: store data
RR3_in  in  REG_W  EX/MEM: destination register
stall_out  out  1  hold EX/MEM and earlier stages (combinational)
mem_req  out  1  memory request (registered)
mem_we  out  1  1=write, 0=read (registered)
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered store data
mem_rdata  in  DATA_W  load data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse
mem_err  out  1  sticky timeout flag
MemToReg_out  out  1  MEM/WB control
RegWrite_out  out  1  MEM/WB control
alu_out  out  DATA_W  MEM/WB ALU result
read_data_out  out  DATA_W  MEM/WB load data
RR3_out  out  REG_W  MEM/WB destination register

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset: all MEM/WB outputs, mem_req, mem_we, mem_addr, mem_wdata, mem_err and the wait counter go to 0. State goes to IDLE. A reset during WAIT abandons the access and drops mem_req on the same edge.
- FSM: two states, IDLE and WAIT.
- IDLE, no memory operation (MemRead_in=MemWrite_in=0):
  - stall_out=0.
  - At the next edge, MEM/WB loads MemToReg_in, RegWrite_in, alu_in and RR3_in; read_data_out is loaded with 0.
  - Latency is 1 cycle.
- IDLE, memory operation:
  - stall_out=1 combinationally.
  - At the edge: latch MemToReg, RegWrite, alu and RR3 internally; mem_req<=1; mem_we<=MemWrite_in; mem_addr<=alu_in[ADDR_W-1:0]; mem_wdata<=RD3_in; wait counter<=0; go to WAIT.
  - MEM/WB is loaded with a bubble (MemToReg_out=RegWrite_out=0, other fields 0).
- MemRead_in and MemWrite_in both 1: the store takes priority (mem_we=1) and read_data_out=0.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - stall_out = !mem_ack.
  - A bubble is written to MEM/WB on each cycle without ack.
  - The counter increments each cycle.
- WAIT with mem_ack=1, at the edge:
  - MEM/WB loads the latched fields; read_data_out<=mem_rdata for a read, 0 for a write.
  - mem_req<=0 and state returns to IDLE.
  - Because stall_out is already 0 in the ack cycle, EX/MEM advances on the same edge.
  - Minimum access is 2 cycles (ack in the first WAIT cycle).
- Timeout: counter==MAX_WAIT-1 and mem_ack=0 in WAIT. At the edge: mem_req<=0, mem_err<=1 (sticky until rst), MEM/WB gets a bubble, state returns to IDLE. stall_out in that cycle is 0, so the faulted instruction is dropped.
- mem_ack while in IDLE is ignored.
- Internal-latch rules: the EX/MEM inputs need not be held stable during WAIT; the block uses its internal latches. All arithmetic is unsigned and the counter is ceil(log2(MAX_WAIT+1)) bits.

Test Plan:
- ALU op: rst then release; RegWrite_in=1, alu_in=100, RR3_in=5, no mem op -> after 1 edge RegWrite_out=1, alu_out=100, RR3_out=5, read_data_out=0, stall_out never 1.
- Load with 3-cycle latency: MemRead_in=1, MemToReg_in=1, RegWrite_in=1, alu_in=0x00040, RR3_in=6; mem_ack pulses 3 cycles after mem_req rises with mem_rdata=321.
  - stall_out=1 from the issue cycle through the 2 non-ack WAIT cycles, and 0 in the ack cycle.
  - mem_addr=0x0040 and mem_we=0 throughout.
  - Bubbles on MEM/WB until the ack edge, then MemToReg_out=1, RegWrite_out=1, read_data_out=321, RR3_out=6.
- Store: MemWrite_in=1, alu_in=0x1F000, RD3_in=400, ack in the first WAIT cycle -> mem_we=1, mem_addr=0xF000, mem_wdata=400; 2-cycle stall; RegWrite_out stays 0.
- Back-to-back: load then an ALU op (alu_in=300) with ack after 2 cycles -> the ALU op is held by the stall and appears on MEM/WB exactly one edge after the load's result, with no duplication.
- Timeout with MAX_WAIT=8: issue a load and never ack -> mem_req is high for exactly 8 cycles, then mem_err=1, RegWrite_out=0, state IDLE. The next ALU op passes normally and mem_err stays 1.
- Reset mid-WAIT: assert rst during the second WAIT cycle -> on the next edge mem_req=0, all outputs 0, mem_err=0. A later ack pulse has no effect.

Source files
------------

// File: rtl/mem_stage_wb_reg.sv
// MEM stage with req/ack data-memory access, upstream stall, MEM/WB pipeline
// register and a timeout watchdog that turns a hung access into a bubble.
module mem_stage_wb_reg #(
    parameter int unsigned DATA_W   = 21,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemToReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] RD3_in,
    input  logic [REG_W-1:0]  RR3_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [REG_W-1:0]  RR3_out
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                lat_mtr;
    logic                lat_rw;
    logic [DATA_W-1:0]   lat_alu;
    logic [REG_W-1:0]    lat_rr3;
    logic                mem_op;
    logic                timeout;

    assign mem_op  = MemRead_in | MemWrite_in;
    assign timeout = (state == S_WAIT) && !mem_ack && (cnt == CNT_W'(MAX_WAIT - 1));

    // The timeout cycle does not stall, so the faulted instruction is dropped.
    always_comb begin
        stall_out = 1'b0;
        if (state == S_IDLE)
            stall_out = mem_op;
        else
            stall_out = !mem_ack && !timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lat_mtr       <= 1'b0;
            lat_rw        <= 1'b0;
            lat_alu       <= '0;
            lat_rr3       <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_err       <= 1'b0;
            MemToReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            alu_out       <= '0;
            read_data_out <= '0;
            RR3_out       <= '0;
        end else begin
            // MEM/WB defaults to a bubble; only retiring instructions override it.
            MemToReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            alu_out       <= '0;
            read_data_out <= '0;
            RR3_out       <= '0;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        lat_mtr   <= MemToReg_in;
                        lat_rw    <= RegWrite_in;
                        lat_alu   <= alu_in;
                        lat_rr3   <= RR3_in;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in;
                        mem_addr  <= alu_in[ADDR_W-1:0];
                        mem_wdata <= RD3_in;
                        cnt       <= '0;
                        state     <= S_WAIT;
                    end else begin
                        MemToReg_out <= MemToReg_in;
                        RegWrite_out <= RegWrite_in;
                        alu_out      <= alu_in;
                        RR3_out      <= RR3_in;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        MemToReg_out  <= lat_mtr;
                        RegWrite_out  <= lat_rw;
                        alu_out       <= lat_alu;
                        RR3_out       <= lat_rr3;
                        read_data_out <= mem_we ? '0 : mem_rdata;
                        mem_req       <= 1'b0;
                        state         <= S_IDLE;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
